// File: rtl/cpu_reg_package.sv
`default_nettype none
// ============================================================================
// Module      : cpu_reg_package
// Description : Shared CPU register bus definitions. Supplies the bus address
//               and data widths, plus the bus-busy responder state type and
//               the latched backend request record.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_reg_package;

    localparam int address_width = 32;
    localparam int data_width    = 32;

    // Responder FSM: IDLE watches the bus, WAIT holds the bus busy until the
    // backend completes the forwarded transaction.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } responder_state_t;

    // Backend request captured at accept time. addr carries the window byte
    // offset, zero-extended to the bus address width.
    typedef struct packed {
        logic                     we;
        logic [3:0]               be;
        logic [address_width-1:0] addr;
        logic [data_width-1:0]    wdata;
    } responder_req_t;

endpackage
`default_nettype wire

// File: rtl/bus_txn_detect.sv
`default_nettype none
// ============================================================================
// Module      : bus_txn_detect
// Description : New-transaction detector for the bus-busy responder. Compares
//               the bus address against the responder window, keeps a
//               one-cycle history of address and write strobe, and flags a
//               new transaction while the responder is idle.
// Ports       : clk_i, reset_i    - module clock, async active-high reset
//               idle_i            - responder is in IDLE
//               we_i, address_i   - bus write strobe and address
//               accept_o          - new in-window transaction (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module bus_txn_detect
    import cpu_reg_package::*;
#(
    parameter logic [address_width-1:0] BaseAddress = 32'h0000_9000,
    parameter int unsigned              WindowBytes = 'h100
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     idle_i,
    input  logic                     we_i,
    input  logic [address_width-1:0] address_i,
    output logic                     accept_o
);

    localparam logic [address_width-1:0] c_last_addr =
        BaseAddress + address_width'(WindowBytes - 1);

    logic [address_width-1:0] r_addr_q;
    logic                     r_we_q;
    logic                     w_in_win;
    logic                     w_new_txn;

    // History tracks the bus every cycle, including while the responder
    // waits, so a transaction still held after completion is not re-accepted.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_addr_q <= '0;
            r_we_q   <= 1'b0;
        end else begin
            r_addr_q <= address_i;
            r_we_q   <= we_i;
        end
    end

    assign w_in_win  = (address_i >= BaseAddress) && (address_i <= c_last_addr);

    // An address change catches pulsed and held reads alike; a rising write
    // strobe catches a repeated write to the same address.
    assign w_new_txn = (address_i != r_addr_q) || (we_i && !r_we_q);

    assign accept_o  = idle_i && w_in_win && w_new_txn;

endmodule
`default_nettype wire

// File: rtl/bus_busy_responder.sv
`default_nettype none
// ============================================================================
// Module      : bus_busy_responder
// Description : Module-side CPU register bus endpoint. Forwards new in-window
//               transactions to a backend over a req/ack handshake and holds
//               busy_o high until the backend completes, so the bus crossing
//               captures read data on the busy falling edge.
// Ports       : clk_i, reset_i         - module clock, async active-high reset
//               we_i, we_ram_i         - bus write strobe and byte enables
//               address_i, data_i      - bus address and write data
//               rdata_o, busy_o        - read data and busy toward the bus
//               req_o, req_we_o,
//               req_be_o, req_addr_o,
//               req_wdata_o            - backend request (byte offset address)
//               ack_i, ack_rdata_i     - backend completion pulse and data
//               timeout_o              - sticky timeout flag (timeout build)
// Build macro : BUS_RESPONDER_TIMEOUT_EN - forces completion after
//               TimeoutCycles waiting cycles and adds timeout_o.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_busy_responder
    import cpu_reg_package::*;
#(
    parameter logic [address_width-1:0] BaseAddress   = 32'h0000_9000,
    parameter int unsigned              WindowBytes   = 'h100,
    parameter int unsigned              TimeoutCycles = 1024,
    parameter logic [data_width-1:0]    TimeoutData   = 32'hDEAD_BEEF
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           we_i,
    input  logic [3:0]                     we_ram_i,
    input  logic [address_width-1:0]       address_i,
    input  logic [data_width-1:0]          data_i,
    output logic [data_width-1:0]          rdata_o,
    output logic                           busy_o,
    output logic                           req_o,
    output logic                           req_we_o,
    output logic [3:0]                     req_be_o,
    output logic [$clog2(WindowBytes)-1:0] req_addr_o,
    output logic [data_width-1:0]          req_wdata_o,
`ifdef BUS_RESPONDER_TIMEOUT_EN
    output logic                           timeout_o,
`endif
    input  logic                           ack_i,
    input  logic [data_width-1:0]          ack_rdata_i
);

    localparam int c_offset_width = $clog2(WindowBytes);

    responder_state_t            r_state;
    responder_req_t              r_req;
    logic                        r_req_valid;
    logic [data_width-1:0]       r_rdata;
    logic                        w_accept;
    logic [3:0]                  w_be;
    logic [c_offset_width-1:0]   w_offset;
    logic                        w_unused_req_addr;

`ifdef BUS_RESPONDER_TIMEOUT_EN
    localparam int c_to_width = $clog2(TimeoutCycles + 1);
    localparam logic [c_to_width-1:0] c_to_last = c_to_width'(TimeoutCycles - 1);

    logic [c_to_width-1:0] r_to_count;
    logic                  r_timeout;
`endif

    bus_txn_detect #(
        .BaseAddress (BaseAddress),
        .WindowBytes (WindowBytes)
    ) u_detect (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .idle_i    (r_state == IDLE),
        .we_i      (we_i),
        .address_i (address_i),
        .accept_o  (w_accept)
    );

    // A write with no byte lanes selected means a full-word write.
    always_comb begin
        w_be = 4'h0;
        if (we_i) begin
            w_be = (we_ram_i == 4'h0) ? 4'hF : we_ram_i;
        end
    end

    // Only the low offset bits matter, and modular subtraction on the low
    // bits alone gives the same result as the full-width difference.
    assign w_offset = address_i[c_offset_width-1:0] - BaseAddress[c_offset_width-1:0];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= IDLE;
            r_req       <= '0;
            r_req_valid <= 1'b0;
            r_rdata     <= '0;
`ifdef BUS_RESPONDER_TIMEOUT_EN
            r_to_count  <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req.we    <= we_i;
                        r_req.be    <= w_be;
                        r_req.addr  <= address_width'(w_offset);
                        r_req.wdata <= data_i;
                        r_req_valid <= 1'b1;
                        r_state     <= WAIT;
`ifdef BUS_RESPONDER_TIMEOUT_EN
                        r_to_count  <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (ack_i) begin
                        r_req_valid <= 1'b0;
                        r_state     <= IDLE;
                        if (!r_req.we) begin
                            r_rdata <= ack_rdata_i;
                        end
                    end
`ifdef BUS_RESPONDER_TIMEOUT_EN
                    // Last waiting cycle with no ack: complete with the
                    // timeout pattern. An ack in this same cycle wins above.
                    else if (r_to_count == c_to_last) begin
                        r_req_valid <= 1'b0;
                        r_state     <= IDLE;
                        r_timeout   <= 1'b1;
                        if (!r_req.we) begin
                            r_rdata <= TimeoutData;
                        end
                    end else begin
                        r_to_count <= r_to_count + c_to_width'(1);
                    end
`endif
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // busy is combinational on accept so a bypass-path CPU stalls in the
    // cycle the transaction appears.
    assign busy_o      = w_accept | (r_state == WAIT);
    assign req_o       = r_req_valid;
    assign req_we_o    = r_req.we;
    assign req_be_o    = r_req.be;
    assign req_addr_o  = r_req.addr[c_offset_width-1:0];
    assign req_wdata_o = r_req.wdata;
    assign rdata_o     = r_rdata;

    // Upper offset bits are always zero; fold them so they are consumed.
    assign w_unused_req_addr = ^r_req.addr;

`ifdef BUS_RESPONDER_TIMEOUT_EN
    assign timeout_o = r_timeout;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_busy_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_busy_responder
// Description : Self-checking bench for bus_busy_responder. Applies a
//               cycle-by-cycle vector table, hand-written multi-cycle
//               sequences and randomized traffic compared against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_busy_responder;

    localparam logic [31:0] BASE   = 32'h0000_9000;
    localparam logic [31:0] WIN    = 32'h0000_0100;
    localparam int          TOC    = 8;
    localparam logic [31:0] TODATA = 32'hDEAD_BEEF;
`ifdef BUS_RESPONDER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        we_i;
    logic [3:0]  we_ram_i;
    logic [31:0] address_i;
    logic [31:0] data_i;
    logic [31:0] rdata_o;
    logic        busy_o;
    logic        req_o;
    logic        req_we_o;
    logic [3:0]  req_be_o;
    logic [7:0]  req_addr_o;
    logic [31:0] req_wdata_o;
    logic        ack_i;
    logic [31:0] ack_rdata_i;
`ifdef BUS_RESPONDER_TIMEOUT_EN
    logic        timeout_o;
`endif

    bus_busy_responder #(
        .BaseAddress   (BASE),
        .WindowBytes   ('h100),
        .TimeoutCycles (TOC),
        .TimeoutData   (TODATA)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .we_i        (we_i),
        .we_ram_i    (we_ram_i),
        .address_i   (address_i),
        .data_i      (data_i),
        .rdata_o     (rdata_o),
        .busy_o      (busy_o),
        .req_o       (req_o),
        .req_we_o    (req_we_o),
        .req_be_o    (req_be_o),
        .req_addr_o  (req_addr_o),
        .req_wdata_o (req_wdata_o),
`ifdef BUS_RESPONDER_TIMEOUT_EN
        .timeout_o   (timeout_o),
`endif
        .ack_i       (ack_i),
        .ack_rdata_i (ack_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: one outstanding transaction, tracked as a record.
    // ------------------------------------------------------------------
    bit          m_busy;
    logic [31:0] m_pa;
    bit          m_pwe;
    bit          m_rwe;
    logic [3:0]  m_rbe;
    logic [31:0] m_raddr;
    logic [31:0] m_rwdata;
    logic [31:0] m_rdata;
    bit          m_to;
    int          m_wait;
    int          ack_cd;
    bit          last_req;
    int          n_req_rise;

    function automatic bit in_win(input logic [31:0] a);
        logic [31:0] d;
        d = a - BASE;
        return d < WIN;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_pa = '0; m_pwe = 0; m_rwe = 0; m_rbe = '0;
        m_raddr = '0; m_rwdata = '0; m_rdata = '0; m_to = 0; m_wait = 0;
        ack_cd = 0; last_req = 0;
    endtask

    task automatic model_finish(input logic [31:0] d, input bit by_timeout);
        m_busy = 0;
        if (!m_rwe) m_rdata = d;
        if (by_timeout) m_to = 1;
    endtask

    task automatic reset_dut();
        @(negedge clk_i);
        reset_i = 1; we_i = 0; we_ram_i = '0; address_i = '0; data_i = '0;
        ack_i = 0; ack_rdata_i = '0;
        @(negedge clk_i);
        reset_i = 0;
        model_reset();
    endtask

    // One bus cycle: drive, compare against the model, clock, advance model.
    task automatic cycle(input logic [31:0] a, input bit we, input logic [3:0] be,
                         input logic [31:0] wd, input bit ack, input logic [31:0] ad);
        bit acc;
        @(negedge clk_i);
        address_i = a; we_i = we; we_ram_i = be; data_i = wd;
        ack_i = ack; ack_rdata_i = ad;
        #1;
        acc = !m_busy && in_win(a) && (a != m_pa || (we && !m_pwe));
        chk("busy", busy_o, acc || m_busy);
        chk("req", req_o, m_busy);
        chk("rdata", rdata_o, m_rdata);
        if (m_busy) begin
            chk("req_we", req_we_o, m_rwe);
            chk("req_be", req_be_o, m_rbe);
            chk("req_addr", req_addr_o, m_raddr[7:0]);
            chk("req_wdata", req_wdata_o, m_rwdata);
        end
`ifdef BUS_RESPONDER_TIMEOUT_EN
        chk("timeout", timeout_o, m_to);
`endif
        if (req_o && !last_req) n_req_rise++;
        last_req = req_o;
        @(posedge clk_i);
        if (m_busy) begin
            m_wait++;
            if (ack) model_finish(ad, 0);
            else if (TO_EN && m_wait == TOC) model_finish(TODATA, 1);
        end else if (acc) begin
            m_busy   = 1;
            m_wait   = 0;
            m_rwe    = we;
            m_rbe    = !we ? 4'h0 : (be == 4'h0 ? 4'hF : be);
            m_raddr  = a - BASE;
            m_rwdata = wd;
            ack_cd   = int'($urandom_range(1, 12));
        end
        m_pa  = a;
        m_pwe = we;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] addr;
        bit          we;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          ack;
        logic [31:0] adata;
        bit          e_busy;
        bit          e_req;
        logic [31:0] e_rdata;
        bit          e_chk;
        bit          e_we;
        logic [3:0]  e_be;
        logic [7:0]  e_addr;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(input logic [31:0] addr, input bit we, input logic [3:0] be,
                                input logic [31:0] wdata, input bit ack, input logic [31:0] adata,
                                input bit e_busy, input bit e_req, input logic [31:0] e_rdata,
                                input bit e_chk, input bit e_we, input logic [3:0] e_be,
                                input logic [7:0] e_addr, input logic [31:0] e_wdata);
        vec_t v;
        v.addr = addr; v.we = we; v.be = be; v.wdata = wdata; v.ack = ack; v.adata = adata;
        v.e_busy = e_busy; v.e_req = e_req; v.e_rdata = e_rdata; v.e_chk = e_chk;
        v.e_we = e_we; v.e_be = e_be; v.e_addr = e_addr; v.e_wdata = e_wdata;
        return v;
    endfunction

    logic [31:0] ra;
    bit          rwe;
    bit          rack;

    initial begin
        // Read at 'h9010, busy 4 cycles, ack in the third req cycle.
        tbl[0]  = mk(32'h9010, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        tbl[1]  = mk(32'h9010, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0,          1'b1, 1'b1, 32'h0,        1'b1, 1'b0, 4'h0, 8'h10, 32'h0);
        tbl[2]  = mk(32'h9010, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0,          1'b1, 1'b1, 32'h0,        1'b1, 1'b0, 4'h0, 8'h10, 32'h0);
        tbl[3]  = mk(32'h9010, 1'b0, 4'h0, 32'h0, 1'b1, 32'h1234_5678,  1'b1, 1'b1, 32'h0,        1'b1, 1'b0, 4'h0, 8'h10, 32'h0);
        tbl[4]  = mk(32'h9010, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0,          1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        // Write with no byte enables: full word, read data unchanged.
        tbl[5]  = mk(32'h9004, 1'b1, 4'h0, 32'hA5A5_0000, 1'b0, 32'h0,  1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        tbl[6]  = mk(32'h9004, 1'b1, 4'h0, 32'hA5A5_0000, 1'b0, 32'h0,  1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b1, 4'hF, 8'h04, 32'hA5A5_0000);
        tbl[7]  = mk(32'h9004, 1'b1, 4'h0, 32'hA5A5_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b1, 4'hF, 8'h04, 32'hA5A5_0000);
        tbl[8]  = mk(32'h9004, 1'b1, 4'h0, 32'hA5A5_0000, 1'b0, 32'h0,  1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        // Just past the window: ignored for read and write.
        tbl[9]  = mk(32'h9100, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0,          1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        tbl[10] = mk(32'h9100, 1'b1, 4'h3, 32'h0, 1'b0, 32'h0,          1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        // Last word of the window with minimum (2-cycle) busy.
        tbl[11] = mk(32'h90FC, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        tbl[12] = mk(32'h90FC, 1'b0, 4'h0, 32'h0, 1'b1, 32'hCAFE_F00D,  1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 4'h0, 8'hFC, 32'h0);
        // Just below the window.
        tbl[13] = mk(32'h8FFC, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0,          1'b0, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        // First word of the window.
        tbl[14] = mk(32'h9000, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0,          1'b1, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        tbl[15] = mk(32'h9000, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0000_0001,  1'b1, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 4'h0, 8'h00, 32'h0);
        tbl[16] = mk(32'h9000, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        // Late ack while idle is ignored.
        tbl[17] = mk(32'h9000, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0000_0BAD,  1'b0, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);

        // Reset state
        reset_i = 1; we_i = 0; we_ram_i = '0; address_i = '0; data_i = '0;
        ack_i = 0; ack_rdata_i = '0;
        model_reset();
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_req", req_o, 1'b0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_req_we", req_we_o, 1'b0);
        chk("rst_req_be", req_be_o, 4'h0);
        chk("rst_req_addr", req_addr_o, 8'h00);
        chk("rst_req_wdata", req_wdata_o, 32'h0);
`ifdef BUS_RESPONDER_TIMEOUT_EN
        chk("rst_timeout", timeout_o, 1'b0);
`endif
        @(negedge clk_i);
        reset_i = 0;

        // Table-driven directed vectors
        for (int i = 0; i < 18; i++) begin
            @(negedge clk_i);
            address_i = tbl[i].addr; we_i = tbl[i].we; we_ram_i = tbl[i].be;
            data_i = tbl[i].wdata; ack_i = tbl[i].ack; ack_rdata_i = tbl[i].adata;
            #1;
            chk($sformatf("tbl%0d_busy", i), busy_o, tbl[i].e_busy);
            chk($sformatf("tbl%0d_req", i), req_o, tbl[i].e_req);
            chk($sformatf("tbl%0d_rdata", i), rdata_o, tbl[i].e_rdata);
            if (tbl[i].e_chk) begin
                chk($sformatf("tbl%0d_req_we", i), req_we_o, tbl[i].e_we);
                chk($sformatf("tbl%0d_req_be", i), req_be_o, tbl[i].e_be);
                chk($sformatf("tbl%0d_req_addr", i), req_addr_o, tbl[i].e_addr);
                chk($sformatf("tbl%0d_req_wdata", i), req_wdata_o, tbl[i].e_wdata);
            end
        end

        // Bypass-style read held for 20 cycles: exactly one request.
        reset_dut();
        n_req_rise = 0;
        for (int i = 0; i < 20; i++)
            cycle(32'h9020, 1'b0, 4'h0, 32'h0, m_busy && m_wait == 1, 32'h0000_2020);
        chk("hold_one_request", n_req_rise, 1);
        for (int i = 0; i < 6; i++)
            cycle(32'h9024, 1'b0, 4'h0, 32'h0, m_busy && m_wait == 1, 32'h0000_2424);
        chk("hold_second_request", n_req_rise, 2);
        chk("hold_rdata", rdata_o, 32'h0000_2424);

        // Reset in WAIT abandons the request; a later ack does nothing.
        reset_dut();
        cycle(32'h9030, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
        cycle(32'h9030, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk_i);
        reset_i = 1; address_i = '0;
        #1;
        chk("rst_wait_req", req_o, 1'b0);
        chk("rst_wait_busy", busy_o, 1'b0);
        @(negedge clk_i);
        reset_i = 0;
        model_reset();
        cycle(32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0000_0077);
        cycle(32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
        chk("late_ack_rdata", rdata_o, 32'h0);

`ifdef BUS_RESPONDER_TIMEOUT_EN
        // No ack: forced completion with the timeout pattern.
        reset_dut();
        cycle(32'h9040, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) cycle(32'h9040, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk_i); #1;
        chk("to_rdata", rdata_o, 32'hDEAD_BEEF);
        chk("to_flag", timeout_o, 1'b1);
        // Ack in the timeout cycle wins.
        reset_dut();
        cycle(32'h9044, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++)
            cycle(32'h9044, 1'b0, 4'h0, 32'h0, m_busy && m_wait == TOC - 1, 32'h5555_AAAA);
        @(negedge clk_i); #1;
        chk("to_ack_rdata", rdata_o, 32'h5555_AAAA);
        chk("to_ack_flag", timeout_o, 1'b0);
`endif

        // Randomized traffic against the model.
        reset_dut();
        ra = BASE;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 9))
                    6:       ra = BASE - 32'd4;
                    7:       ra = BASE + WIN;
                    8:       ra = BASE + WIN - 32'd4;
                    9:       ra = $urandom;
                    default: ra = BASE + 32'(4 * $urandom_range(0, 63));
                endcase
            end
            rwe = ($urandom_range(0, 2) == 0);
            if (m_busy) begin
                rack = (ack_cd <= 1);
                ack_cd--;
            end else begin
                rack = ($urandom_range(0, 7) == 0);
            end
            cycle(ra, rwe, 4'($urandom_range(0, 15)), $urandom, rack, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
